// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, lock limit
// and the two-bit ownership state encoding.
package dmem_arbiter_pkg;

  localparam int DMEM_AW       = 8;
  localparam int DMEM_DW       = 8;
  localparam int DMEM_LOCK_MAX = 15;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  // Ownership handed over on contention; anything that is not an owner maps to IDLE.
  function automatic state_t other_owner(input state_t s);
    case (s)
      ST_OWN_A: return ST_OWN_B;
      ST_OWN_B: return ST_OWN_A;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// Routes the owning requester's address, write data and write strobe onto the
// data-memory port; drives zeros when nobody owns the memory.
module dmem_port_mux
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic          i_sel_a,
  input  logic          i_sel_b,
  input  logic          i_a_req,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  input  logic          i_b_req,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata
);

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_sel_a) begin
      o_mem_we    = i_a_req & i_a_we;
      o_mem_addr  = i_a_addr;
      o_mem_wdata = i_a_wdata;
    end else if (i_sel_b) begin
      o_mem_we    = i_b_req & i_b_we;
      o_mem_addr  = i_b_addr;
      o_mem_wdata = i_b_wdata;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin ownership FSM with optional
// bounded lock hold, enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int LOCK_MAX = DMEM_LOCK_MAX
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_owning;
  logic   w_own_req;
  logic   w_oth_req;
  logic   w_lock_hold;
  logic   w_mux_we;

  assign w_owning  = (r_state == ST_OWN_A) || (r_state == ST_OWN_B);
  assign w_own_req = (r_state == ST_OWN_A) ? a_req : b_req;
  assign w_oth_req = (r_state == ST_OWN_A) ? b_req : a_req;

`ifdef DMEM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] r_lock_cnt;
  logic [CW-1:0] w_lock_cnt_inc;
  logic          w_own_lock;

  assign w_own_lock     = w_owning && w_own_req &&
                          ((r_state == ST_OWN_A) ? a_lock : b_lock);
  assign w_lock_cnt_inc = (r_lock_cnt == CW'(LOCK_MAX)) ? r_lock_cnt : r_lock_cnt + 1'b1;
  // The cycle whose locked count reaches LOCK_MAX no longer holds ownership.
  assign w_lock_hold    = w_own_lock && (w_lock_cnt_inc != CW'(LOCK_MAX));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lock_cnt <= '0;
    end else if (w_own_lock && (w_state_nxt == r_state)) begin
      r_lock_cnt <= w_lock_cnt_inc;
    end else begin
      r_lock_cnt <= '0;
    end
  end
`else
  logic w_unused_lock;

  assign w_lock_hold   = 1'b0;
  assign w_unused_lock = a_lock ^ b_lock ^ (LOCK_MAX != 0);
`endif

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (!w_owning) begin
      if (a_req) begin
        w_state_nxt = ST_OWN_A;
      end else if (b_req) begin
        w_state_nxt = ST_OWN_B;
      end
    end else if (w_lock_hold) begin
      w_state_nxt = r_state;
    end else if (w_oth_req) begin
      w_state_nxt = other_owner(r_state);
    end else if (w_own_req) begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign a_gnt = (r_state == ST_OWN_A);
  assign b_gnt = (r_state == ST_OWN_B);

  dmem_port_mux #(
    .AW (AW),
    .DW (DW)
  ) u_port_mux (
    .i_sel_a     (a_gnt),
    .i_sel_b     (b_gnt),
    .i_a_req     (a_req),
    .i_a_we      (a_we),
    .i_a_addr    (a_addr),
    .i_a_wdata   (a_wdata),
    .i_b_req     (b_req),
    .i_b_we      (b_we),
    .i_b_addr    (b_addr),
    .i_b_wdata   (b_wdata),
    .o_mem_we    (w_mux_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata)
  );

  // A write must never land in a cycle where reset is being sampled.
  assign mem_we = w_mux_we & ~Reset;
  assign rdata  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8: address width, matching the 256-deep data memory.
REQ-002 SHALL have parameter DW, default 8: data width.
REQ-003 SHALL have parameter LOCK_MAX, default 15: maximum consecutive locked grant cycles to one requester.
REQ-004 Clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 a_req / a_we / a_lock  in  1 each  requester A (core) request, write enable, lock hold.
REQ-007 a_addr  in  AW, a_wdata  in  DW  requester A address and write data.
REQ-008 a_gnt  out  1  A owns the memory this cycle.
REQ-009 b_req / b_we / b_lock  in  1 each, b_addr  in  AW, b_wdata  in  DW  requester B (loader/DMA) equivalents.
REQ-010 b_gnt  out  1  B owns the memory this cycle.
REQ-011 mem_we  out  1, mem_addr  out  AW, mem_wdata  out  DW  drive the data-memory write-enable, address and write-data inputs.
REQ-012 mem_rdata  in  DW  combinational read data from memory; rdata  out  DW  SHALL equal mem_rdata.

Function
REQ-013 SHALL implement the FSM states IDLE, OWN_A and OWN_B; a_gnt SHALL be 1 only in OWN_A, b_gnt only in OWN_B (registered, never both).
REQ-014 From IDLE: a_req -> OWN_A; else b_req -> OWN_B; else stay in IDLE (A wins on a simultaneous first request).
REQ-015 From OWN_X: lock active and X's req high -> stay; else other requester's req high -> OWN_other; else X's req high -> stay; else IDLE (round-robin on contention).
REQ-016 Grant latency SHALL be 1 cycle: a request first seen at edge N is granted during cycle N+1 at the earliest; requesters SHALL hold req/addr/we/wdata until granted.
REQ-017 In OWN_X, mem_addr/mem_wdata SHALL mux X's inputs; mem_we = X_gnt & X_req & X_we; in IDLE mem_we SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-018 A grant cycle with the owner's req low SHALL perform no write.
REQ-019 A read SHALL complete in the grant cycle: rdata is valid combinationally while the owner's grant is high.
REQ-020 Lock counter SHALL count consecutive locked cycles saturating at LOCK_MAX; when it reaches LOCK_MAX, the lock SHALL be ignored for the next transition and the counter SHALL clear on any owner change or IDLE.

Reset
REQ-021 Reset SHALL force IDLE, a_gnt=0, b_gnt=0, mem_we=0 and the lock counter to 0 at the next edge, including mid-locked sequences; no write SHALL occur in the cycle Reset is sampled high.

Configuration
REQ-022 Macro DMEM_ARB_LOCK_EN defined: a_lock/b_lock and the lock counter behave per REQ-015/REQ-020.
REQ-023 Macro DMEM_ARB_LOCK_EN undefined: lock inputs SHALL be ignored and no lock counter SHALL be built; arbitration is pure round-robin per REQ-015.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (IDLE=0, OWN_A=1, OWN_B=2, 2 bits) and the default AW/DW constants.
REQ-025 The port mux SHALL be one sub-module, dmem_port_mux, selecting address/data/we by owner; the FSM stays in dmem_arbiter.

Verification
REQ-026 After Reset, a_req=1, a_we=1, a_addr=0x10, a_wdata=0x80 -> a_gnt=1 on the next cycle, mem_we=1, and memory[0x10]=0x80 afterward.
REQ-027 a_req and b_req both rise in the same cycle with reads of 0xF4/0x20 -> A is granted first, then B in the following cycle; rdata is the read data for 0xF4 during A's grant cycle.
REQ-028 a_req and b_req held high continuously -> grants alternate A,B,A,B with no gap cycles.
REQ-029 With DMEM_ARB_LOCK_EN defined, a_lock=1 and a_req=1 held while b_req=1 -> A is held for 15 cycles, then B is granted; with the macro undefined -> alternation as in REQ-028.
REQ-030 Reset asserted in OWN_B while b_we=1 -> the next cycle shows b_gnt=0 and IDLE, and memory is unchanged.
REQ-031 In OWN_A, a_req drops with a_we=1 -> mem_we=0, and the FSM goes to IDLE or OWN_B per b_req.
